// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: opcode constants,
// branch funct3 encodings and the 2-bit history-counter states.
package branch_pkg;

  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } fun3_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

endpackage

// File: rtl/branch_resolve_unit_bht_counter.sv
// One 2-bit saturating branch-history counter. Resets to weakly-not-taken.
module bht_counter
  import branch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       taken,
  output logic [1:0] state
);

  logic [1:0] r_state;

  // Saturating increment on taken, saturating decrement on not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WNT;
    end else if (en) begin
      if (taken) begin
        if (r_state != ST) r_state <= r_state + 2'd1;
      end else begin
        if (r_state != SNT) r_state <= r_state - 2'd1;
      end
    end
  end

  assign state = r_state;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves conditional branches and jumps in execute,
// predicts fetch-stage branches from a table of 2-bit counters indexed by
// pc[IDX_W+1:2], and keeps branch/mispredict statistics.
// ex_valid qualifies every execute-stage input: with ex_valid low the outcome
// is still computed but nothing is counted, no table entry changes and
// mispredict stays low.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_f,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] pc_e,
  input  logic [6:0]      opcode,
  input  logic [2:0]      fun3,
  input  logic [XLEN-1:0] forwarded_A,
  input  logic [XLEN-1:0] forwarded_B,
  input  logic            ex_pred_taken,
  output logic            br_taken,
  output logic            mispredict,
  input  logic            clear_stats,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [IDX_W-1:0] w_idx_f;
  logic [IDX_W-1:0] w_idx_e;
  logic             w_is_cond;
  logic             w_is_jump;
  logic             w_cond_taken;
  logic             w_update;
  logic [1:0]       w_state [BHT_ENTRIES];
  logic             w_unused;

  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_miss_count;

  assign w_idx_f = pc_f[IDX_W+1:2];
  assign w_idx_e = pc_e[IDX_W+1:2];

  // PC bits outside the index field carry no information for this unit.
  assign w_unused = ^{pc_f[XLEN-1:IDX_W+2], pc_f[1:0],
                      pc_e[XLEN-1:IDX_W+2], pc_e[1:0]};

  // Conditional-branch comparison; reserved funct3 codes are not branches.
  always_comb begin
    w_is_cond    = 1'b0;
    w_cond_taken = 1'b0;
    if (opcode == BRANCH) begin
      w_is_cond = 1'b1;
      case (fun3)
        BEQ:     w_cond_taken = (forwarded_A == forwarded_B);
        BNE:     w_cond_taken = (forwarded_A != forwarded_B);
        BLT:     w_cond_taken = ($signed(forwarded_A) <  $signed(forwarded_B));
        BGE:     w_cond_taken = ($signed(forwarded_A) >= $signed(forwarded_B));
        BLTU:    w_cond_taken = (forwarded_A <  forwarded_B);
        BGEU:    w_cond_taken = (forwarded_A >= forwarded_B);
        default: w_is_cond    = 1'b0;
      endcase
    end
  end

  assign w_is_jump  = (opcode == JAL) || (opcode == JALR);
  assign br_taken   = w_is_jump | w_cond_taken;
  assign mispredict = ex_valid & (w_is_cond | w_is_jump) & (br_taken ^ ex_pred_taken);
  assign w_update   = ex_valid & w_is_cond;

  // History table: only a valid legal conditional branch trains its entry.
  for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
    bht_counter u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_update && (w_idx_e == IDX_W'(gi))),
      .taken (br_taken),
      .state (w_state[gi])
    );
  end

  // Prediction reads the registered entry, so a same-cycle update is not seen.
  assign pred_taken = w_state[w_idx_f][1];

  // Statistics counters: clear dominates, otherwise saturating increments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_count   <= '0;
      r_miss_count <= '0;
    end else if (clear_stats) begin
      r_br_count   <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_update && (r_br_count != {CNT_W{1'b1}}))
        r_br_count <= r_br_count + 1'b1;
      if (mispredict && (r_miss_count != {CNT_W{1'b1}}))
        r_miss_count <= r_miss_count + 1'b1;
    end
  end

  assign br_count   = r_br_count;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_f;
  logic        pred_taken;
  logic        ex_valid;
  logic [31:0] pc_e;
  logic [6:0]  opcode;
  logic [2:0]  fun3;
  logic [31:0] forwarded_A;
  logic [31:0] forwarded_B;
  logic        ex_pred_taken;
  logic        br_taken;
  logic        mispredict;
  logic        clear_stats;
  logic [31:0] br_count;
  logic [31:0] miss_count;

  int n_checks = 0;
  int n_errors = 0;

  branch_resolve_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_f          (pc_f),
    .pred_taken    (pred_taken),
    .ex_valid      (ex_valid),
    .pc_e          (pc_e),
    .opcode        (opcode),
    .fun3          (fun3),
    .forwarded_A   (forwarded_A),
    .forwarded_B   (forwarded_B),
    .ex_pred_taken (ex_pred_taken),
    .br_taken      (br_taken),
    .mispredict    (mispredict),
    .clear_stats   (clear_stats),
    .br_count      (br_count),
    .miss_count    (miss_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one execute-stage instruction and let combinational logic settle.
  task automatic drive_ex(input logic v, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic pt, input logic [31:0] pc);
    ex_valid      = v;
    opcode        = op;
    fun3          = f3;
    forwarded_A   = a;
    forwarded_B   = b;
    ex_pred_taken = pt;
    pc_e          = pc;
    #1;
  endtask

  task automatic idle_ex();
    drive_ex(1'b0, OP_ALU, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Advance one clock; inputs return to idle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    idle_ex();
    clear_stats = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    pc_f        = 32'h100;
    clear_stats = 1'b0;
    idle_ex();
    #12;
    // Reset state
    check("rst_br_count", br_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    check("rst_pred_0x100", {31'd0, pred_taken}, 32'd0);
    check("rst_entry5", {30'd0, dut.w_state[5]}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // BEQ taken at 0x100, same index on fetch: prediction is pre-update
    pc_f = 32'h100;
    drive_ex(1'b1, OP_BR, 3'b000, 32'd5, 32'd5, 1'b0, 32'h100);
    check("beq_pred_pre", {31'd0, pred_taken}, 32'd0);
    check("beq_taken", {31'd0, br_taken}, 32'd1);
    check("beq_miss", {31'd0, mispredict}, 32'd1);
    tick();
    check("beq_pred_post", {31'd0, pred_taken}, 32'd1);
    check("beq_entry0", {30'd0, dut.w_state[0]}, 32'd2);
    check("beq_br_count", br_count, 32'd1);
    check("beq_miss_count", miss_count, 32'd1);

    // Signed/unsigned comparisons with ex_valid low (no update, no mispredict)
    drive_ex(1'b0, OP_BR, 3'b101, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'h100);
    check("bge_neg", {31'd0, br_taken}, 32'd0);
    check("invalid_no_miss", {31'd0, mispredict}, 32'd0);
    drive_ex(1'b0, OP_BR, 3'b111, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'h100);
    check("bgeu_big", {31'd0, br_taken}, 32'd1);
    drive_ex(1'b0, OP_BR, 3'b101, 32'd7, 32'd7, 1'b0, 32'h100);
    check("bge_eq", {31'd0, br_taken}, 32'd1);
    drive_ex(1'b0, OP_BR, 3'b100, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'h100);
    check("blt_neg", {31'd0, br_taken}, 32'd1);
    drive_ex(1'b0, OP_BR, 3'b110, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'h100);
    check("bltu_big", {31'd0, br_taken}, 32'd0);
    drive_ex(1'b0, OP_BR, 3'b001, 32'd7, 32'd7, 1'b0, 32'h100);
    check("bne_eq", {31'd0, br_taken}, 32'd0);
    tick();
    check("invalid_entry0", {30'd0, dut.w_state[0]}, 32'd2);
    check("invalid_br_count", br_count, 32'd1);

    // JAL mispredicted: counts a miss, leaves table and branch count alone
    drive_ex(1'b1, OP_JAL, 3'b000, 32'd0, 32'd0, 1'b0, 32'h100);
    check("jal_taken", {31'd0, br_taken}, 32'd1);
    check("jal_miss", {31'd0, mispredict}, 32'd1);
    tick();
    check("jal_miss_count", miss_count, 32'd2);
    check("jal_br_count", br_count, 32'd1);
    check("jal_entry0", {30'd0, dut.w_state[0]}, 32'd2);

    // JALR correctly predicted, non-branch opcode
    drive_ex(1'b1, OP_JALR, 3'b000, 32'd0, 32'd0, 1'b1, 32'h100);
    check("jalr_taken", {31'd0, br_taken}, 32'd1);
    check("jalr_no_miss", {31'd0, mispredict}, 32'd0);
    drive_ex(1'b1, OP_ALU, 3'b000, 32'd3, 32'd3, 1'b1, 32'h100);
    check("alu_taken", {31'd0, br_taken}, 32'd0);
    check("alu_no_miss", {31'd0, mispredict}, 32'd0);
    tick();
    check("alu_miss_count", miss_count, 32'd2);

    // Clear wins over a coincident mispredict
    drive_ex(1'b1, OP_JAL, 3'b000, 32'd0, 32'd0, 1'b0, 32'h100);
    clear_stats = 1'b1;
    tick();
    check("clr_miss_count", miss_count, 32'd0);
    check("clr_br_count", br_count, 32'd0);

    // Reserved funct3: no outcome, no count, no update
    drive_ex(1'b1, OP_BR, 3'b010, 32'd5, 32'd5, 1'b0, 32'h100);
    check("f3_010_taken", {31'd0, br_taken}, 32'd0);
    tick();
    check("f3_010_br_count", br_count, 32'd0);
    check("f3_010_entry0", {30'd0, dut.w_state[0]}, 32'd2);

    // Saturation sequence at 0x200 from a fresh table
    do_reset();
    pc_f = 32'h200;
    check("sat_start", {30'd0, dut.w_state[0]}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive_ex(1'b1, OP_BR, 3'b001, 32'd1, 32'd2, 1'b0, 32'h200);
      tick();
      check($sformatf("sat_up%0d", i), {30'd0, dut.w_state[0]}, (i == 0) ? 32'd2 : 32'd3);
    end
    for (int i = 0; i < 3; i++) begin
      drive_ex(1'b1, OP_BR, 3'b001, 32'd4, 32'd4, 1'b0, 32'h200);
      tick();
      check($sformatf("sat_dn%0d", i), {30'd0, dut.w_state[0]}, 32'd2 - 32'(i));
    end
    check("sat_pred", {31'd0, pred_taken}, 32'd0);
    check("sat_br_count", br_count, 32'd6);
    check("sat_miss_count", miss_count, 32'd3);

    // Asynchronous reset mid-stream with an update pending
    drive_ex(1'b1, OP_BR, 3'b000, 32'd9, 32'd9, 1'b0, 32'h204);
    tick();
    check("pre_rst_entry1", {30'd0, dut.w_state[1]}, 32'd2);
    drive_ex(1'b1, OP_BR, 3'b000, 32'd9, 32'd9, 1'b0, 32'h204);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_entry0", {30'd0, dut.w_state[0]}, 32'd1);
    check("arst_entry1", {30'd0, dut.w_state[1]}, 32'd1);
    check("arst_br_count", br_count, 32'd0);
    check("arst_miss_count", miss_count, 32'd0);
    @(posedge clk);
    #1;
    check("arst_hold_entry1", {30'd0, dut.w_state[1]}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle_ex();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
